// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared opcodes, FSM encoding and latency constants for seq_alu
// Ports: none (package). Optional multiplier opcodes are only decoded when SEQ_ALU_MUL_EN is defined.
package seq_alu_pkg;

   localparam logic [3:0] OP_MOV  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_ADC  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_SBC  = 4'b0101;
   localparam logic [3:0] OP_AND  = 4'b0110;
   localparam logic [3:0] OP_ORR  = 4'b0111;
   localparam logic [3:0] OP_EOR  = 4'b1000;
   localparam logic [3:0] OP_MVN  = 4'b1001;
   localparam logic [3:0] OP_MULL = 4'b1010;
   localparam logic [3:0] OP_MULH = 4'b1011;
   localparam logic [3:0] OP_DIV  = 4'b1100;
   localparam logic [3:0] OP_REM  = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Single-cycle ops present a result one cycle after acceptance; iterative
   // ops present it WIDTH + LAT_ITER_EXTRA cycles after acceptance.
   localparam int LAT_SINGLE     = 1;
   localparam int LAT_ITER_EXTRA = 1;

   // Cycles spent in BUSY: total iterative latency minus the final step into DONE.
   function automatic int busy_cycles(input int width);
      return width + LAT_ITER_EXTRA - LAT_SINGLE;
   endfunction

   function automatic logic is_div_op(input logic [3:0] cmd);
      return (cmd == OP_DIV) || (cmd == OP_REM);
   endfunction

   function automatic logic is_mul_op(input logic [3:0] cmd);
      return (cmd == OP_MULL) || (cmd == OP_MULH);
   endfunction

endpackage

// File: rtl/seq_alu_div.sv
// rtl/seq_alu_div.sv - signed radix-2 restoring divider, one quotient bit per cycle
// Ports: clk, rst (sync active-high); start loads dividend/divisor; done is high during
// the final iteration cycle, when quot/rem already carry the signed final result.
module seq_alu_div
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(busy_cycles(WIDTH) - 1);

   logic             busy;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
   logic             neg_q, neg_r;

   logic [WIDTH:0]   shifted, diff;
   logic             fits;
   logic [WIDTH-1:0] rem_nxt, quo_nxt;
   logic [WIDTH-1:0] mag_dividend, mag_divisor;

   // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
   always_comb begin
      mag_dividend = dividend[WIDTH-1] ? -dividend : dividend;
      mag_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
   end

   // Dividend magnitude shifts out of quo_r MSB-first while quotient bits shift in.
   always_comb begin
      shifted = {rem_r, quo_r[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_r};
      fits    = ~diff[WIDTH];
      rem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_nxt = {quo_r[WIDTH-2:0], fits};
      quot    = neg_q ? -quo_nxt : quo_nxt;
      rem     = neg_r ? -rem_nxt : rem_nxt;
      done    = busy && (cnt == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         cnt   <= '0;
         rem_r <= '0;
         quo_r <= '0;
         dvs_r <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt   <= '0;
         rem_r <= '0;
         quo_r <= mag_dividend;
         dvs_r <= mag_divisor;
         neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r <= dividend[WIDTH-1];
      end else if (busy) begin
         rem_r <= rem_nxt;
         quo_r <= quo_nxt;
         cnt   <= cnt + CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with valid/ready handshakes and iterative divide/multiply
// Ports: clk, rst (sync active-high); in_valid/in_ready command handshake with exe_cmd,
// val1, val2, c_in; out_valid/out_ready result handshake with alu_res, c, v, z, n, dz.
// Define SEQ_ALU_MUL_EN to build the MULL/MULH shift-add multiplier.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              exe_cmd,
   input  logic signed [WIDTH-1:0] val1,
   input  logic signed [WIDTH-1:0] val2,
   input  logic                    c_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        alu_res,
   output logic                    c,
   output logic                    v,
   output logic                    z,
   output logic                    n,
   output logic                    dz
);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state, state_nxt;
   logic             accept;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] val1_r, val2_r;
   logic [WIDTH-1:0] res_r;
   logic             c_r, v_r, z_r, n_r, dz_r;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c, sc_v, sc_dz, sc_known, sc_iter;

   logic             div_start, div_done;
   logic [WIDTH-1:0] div_quot, div_rem;

   logic             it_done, it_v;
   logic [WIDTH-1:0] it_res;

   assign accept = in_valid && (state == ST_IDLE);

   // Single-cycle datapath, evaluated on the raw inputs so the result is
   // captured on the acceptance edge.
   always_comb begin
      sum      = '0;
      sc_res   = '0;
      sc_c     = 1'b0;
      sc_v     = 1'b0;
      sc_dz    = 1'b0;
      sc_known = 1'b1;
      sc_iter  = 1'b0;
      case (exe_cmd)
         OP_MOV: sc_res = val2;
         OP_MVN: sc_res = ~val2;
         OP_ADD, OP_ADC: begin
            sum    = {1'b0, val1} + {1'b0, val2}
                   + {{WIDTH{1'b0}}, (exe_cmd == OP_ADC) && c_in};
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (val1[WIDTH-1] == val2[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);
         end
         OP_SUB, OP_SBC: begin
            // Carry out of val1 + ~val2 + cin means "no borrow".
            sum    = {1'b0, val1} + {1'b0, ~val2}
                   + {{WIDTH{1'b0}}, (exe_cmd == OP_SUB) || c_in};
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (val1[WIDTH-1] != val2[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);
         end
         OP_AND: sc_res = val1 & val2;
         OP_ORR: sc_res = val1 | val2;
         OP_EOR: sc_res = val1 ^ val2;
         OP_DIV, OP_REM: begin
            // Divide-by-zero resolves immediately instead of iterating.
            if (val2 == '0) begin
               sc_res = (exe_cmd == OP_DIV) ? '1 : val1;
               sc_dz  = 1'b1;
            end else begin
               sc_iter = 1'b1;
            end
         end
`ifdef SEQ_ALU_MUL_EN
         OP_MULL, OP_MULH: sc_iter = 1'b1;
`endif
         default: sc_known = 1'b0;
      endcase
   end

   assign div_start = accept && sc_iter && is_div_op(exe_cmd);

   seq_alu_div #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (val1),
      .divisor  (val2),
      .done     (div_done),
      .quot     (div_quot),
      .rem      (div_rem)
   );

`ifdef SEQ_ALU_MUL_EN
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(busy_cycles(WIDTH) - 1);

   logic [2*WIDTH-1:0] mul_p, mul_p_nxt, mul_prod;
   logic [WIDTH-1:0]   mul_mcand;
   logic [WIDTH:0]     mul_sum;
   logic               mul_neg, mul_done, mul_active;
   logic [CNT_W-1:0]   mul_cnt;

   // Magnitude shift-add: the low half of mul_p starts as the multiplier and
   // is consumed LSB-first while the partial product shifts in from the top.
   always_comb begin
      mul_active = (state == ST_BUSY) && is_mul_op(op_r);
      mul_sum    = {1'b0, mul_p[2*WIDTH-1:WIDTH]} + (mul_p[0] ? {1'b0, mul_mcand} : '0);
      mul_p_nxt  = {mul_sum, mul_p[WIDTH-1:1]};
      mul_prod   = mul_neg ? -mul_p_nxt : mul_p_nxt;
      mul_done   = mul_active && (mul_cnt == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_p     <= '0;
         mul_mcand <= '0;
         mul_neg   <= 1'b0;
         mul_cnt   <= '0;
      end else if (accept && is_mul_op(exe_cmd)) begin
         mul_p     <= {{WIDTH{1'b0}}, (val2[WIDTH-1] ? -val2 : val2)};
         mul_mcand <= val1[WIDTH-1] ? -val1 : val1;
         mul_neg   <= val1[WIDTH-1] ^ val2[WIDTH-1];
         mul_cnt   <= '0;
      end else if (mul_active) begin
         mul_p   <= mul_p_nxt;
         mul_cnt <= mul_cnt + CNT_W'(1);
      end
   end
`endif

   // Completion of the iterative op in flight.
   always_comb begin
      it_done = div_done;
      it_res  = (op_r == OP_DIV) ? div_quot : div_rem;
      // Only most-negative / -1 overflows the quotient; the divider already
      // returns val1 for it because the magnitude wraps back to MOST_NEG.
      it_v    = (op_r == OP_DIV) && (val1_r == MOST_NEG) && (val2_r == '1);
`ifdef SEQ_ALU_MUL_EN
      if (is_mul_op(op_r)) begin
         it_done = mul_done;
         it_res  = (op_r == OP_MULL) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = sc_iter ? ST_BUSY : ST_DONE;
            end
         end
         ST_BUSY: begin
            if (it_done) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r   <= '0;
         val1_r <= '0;
         val2_r <= '0;
         res_r  <= '0;
         c_r    <= 1'b0;
         v_r    <= 1'b0;
         z_r    <= 1'b0;
         n_r    <= 1'b0;
         dz_r   <= 1'b0;
      end else if (accept) begin
         op_r   <= exe_cmd;
         val1_r <= val1;
         val2_r <= val2;
         if (!sc_iter) begin
            res_r <= sc_res;
            c_r   <= sc_c;
            v_r   <= sc_v;
            z_r   <= sc_known && (sc_res == '0);
            n_r   <= sc_res[WIDTH-1];
            dz_r  <= sc_dz;
         end
      end else if ((state == ST_BUSY) && it_done) begin
         res_r <= it_res;
         c_r   <= 1'b0;
         v_r   <= it_v;
         z_r   <= (it_res == '0);
         n_r   <= it_res[WIDTH-1];
         dz_r  <= 1'b0;
      end
   end

   assign alu_res = res_r;
   assign c       = c_r;
   assign v       = v_r;
   assign z       = z_r && (state == ST_DONE);
   assign n       = n_r;
   assign dz      = dz_r;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard testbench for seq_alu (WIDTH=32, honours SEQ_ALU_MUL_EN)
module tb_seq_alu;
   localparam int W = 32;
   localparam int ITER_LAT = W + 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    exe_cmd;
   logic [W-1:0]  val1;
   logic [W-1:0]  val2;
   logic          c_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  alu_res;
   logic          c, v, z, n, dz;

   typedef struct packed {
      logic [31:0] res;
      logic        c, v, z, n, dz;
      logic [7:0]  lat;
   } exp_t;

   exp_t sb[$];
   int   tests_run = 0;
   int   fails     = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .exe_cmd   (exe_cmd),
      .val1      (val1),
      .val2      (val2),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_res   (alu_res),
      .c         (c),
      .v         (v),
      .z         (z),
      .n         (n),
      .dz        (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags order: c v z n dz
   function automatic exp_t mk(input logic [31:0] r, input logic [4:0] f, input int lat);
      exp_t e;
      e.res = r;
      {e.c, e.v, e.z, e.n, e.dz} = f;
      e.lat = 8'(lat);
      return e;
   endfunction

   function automatic string fmt(input exp_t x);
      return $sformatf("res=%h c=%b v=%b z=%b n=%b dz=%b lat=%0d",
                       x.res, x.c, x.v, x.z, x.n, x.dz, x.lat);
   endfunction

   // Independent reference model built on SystemVerilog signed arithmetic.
   function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] a,
                                  input logic [31:0] b, input logic ci);
      exp_t        e;
      logic [32:0] s;
      logic        known;
      int          sa, sb2;
      longint      pr;
      logic [63:0] pu;
      e     = '0;
      e.lat = 8'd1;
      known = 1'b1;
      sa    = $signed(a);
      sb2   = $signed(b);
      case (cmd)
         4'h1: e.res = b;
         4'h9: e.res = ~b;
         4'h2, 4'h3: begin
            s     = {1'b0, a} + {1'b0, b} + ((cmd == 4'h3) ? 33'(ci) : 33'd0);
            e.res = s[31:0];
            e.c   = s[32];
            e.v   = (a[31] == b[31]) && (s[31] != a[31]);
         end
         4'h4, 4'h5: begin
            s     = {1'b0, a} + {1'b0, ~b} + ((cmd == 4'h4) ? 33'd1 : 33'(ci));
            e.res = s[31:0];
            e.c   = s[32];
            e.v   = (a[31] != b[31]) && (s[31] != a[31]);
         end
         4'h6: e.res = a & b;
         4'h7: e.res = a | b;
         4'h8: e.res = a ^ b;
         4'hC, 4'hD: begin
            if (b == 32'd0) begin
               e.res = (cmd == 4'hC) ? 32'hFFFF_FFFF : a;
               e.dz  = 1'b1;
            end else begin
               e.lat = 8'(ITER_LAT);
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  e.res = (cmd == 4'hC) ? a : 32'd0;
                  e.v   = (cmd == 4'hC);
               end else begin
                  e.res = (cmd == 4'hC) ? 32'(sa / sb2) : 32'(sa % sb2);
               end
            end
         end
`ifdef SEQ_ALU_MUL_EN
         4'hA, 4'hB: begin
            pr    = longint'(sa) * longint'(sb2);
            pu    = 64'(pr);
            e.res = (cmd == 4'hA) ? pu[31:0] : pu[63:32];
            e.lat = 8'(ITER_LAT);
         end
`endif
         default: known = 1'b0;
      endcase
      if (known) begin
         e.z = (e.res == 32'd0);
         e.n = e.res[31];
      end
      return e;
   endfunction

   // Drives one command, waits (bounded) for its result and returns what the DUT showed.
   task automatic issue_and_collect(input logic [3:0] cmd, input logic [31:0] a,
                                    input logic [31:0] b, input logic ci, output exp_t o);
      int guard;
      int l;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      exe_cmd  = cmd;
      val1     = a;
      val2     = b;
      c_in     = ci;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!out_valid && l < 200);
      o.res = alu_res;
      {o.c, o.v, o.z, o.n, o.dz} = {c, v, z, n, dz};
      o.lat = out_valid ? 8'(l) : 8'hFF;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b, expected in_ready=1 out_valid=0",
                  in_ready, out_valid);
      end
      tests_run++;
      if (alu_res !== 32'd0) begin
         fails++;
         $display("FAIL reset_res: alu_res=%h, expected 00000000", alu_res);
      end
      tests_run++;
      if ({c, v, z, n, dz} !== 5'b0) begin
         fails++;
         $display("FAIL reset_flags: cvznd=%b, expected 00000", {c, v, z, n, dz});
      end
   endtask

   task automatic test_arith();
      logic [3:0]  cmds[10];
      logic [31:0] as[10], bs[10];
      logic        cis[10];
      exp_t        es[10];
      exp_t        o, e;
      cmds[0] = 4'h2; as[0] = 32'h7FFF_FFFF; bs[0] = 32'h1;         cis[0] = 0; es[0] = mk(32'h8000_0000, 5'b01010, 1);
      cmds[1] = 4'h4; as[1] = 32'd5;         bs[1] = 32'd5;         cis[1] = 0; es[1] = mk(32'h0,         5'b10100, 1);
      cmds[2] = 4'h5; as[2] = 32'd5;         bs[2] = 32'd3;         cis[2] = 0; es[2] = mk(32'h1,         5'b10000, 1);
      cmds[3] = 4'h3; as[3] = 32'hFFFF_FFFF; bs[3] = 32'h0;         cis[3] = 1; es[3] = mk(32'h0,         5'b10100, 1);
      cmds[4] = 4'h1; as[4] = 32'h1;         bs[4] = 32'h1234_5678; cis[4] = 1; es[4] = mk(32'h1234_5678, 5'b00000, 1);
      cmds[5] = 4'h9; as[5] = 32'h5;         bs[5] = 32'h0;         cis[5] = 0; es[5] = mk(32'hFFFF_FFFF, 5'b00010, 1);
      cmds[6] = 4'h6; as[6] = 32'hF0F0_F0F0; bs[6] = 32'hFF00_FF00; cis[6] = 0; es[6] = mk(32'hF000_F000, 5'b00010, 1);
      cmds[7] = 4'h7; as[7] = 32'h0F0F_0000; bs[7] = 32'h0000_00F0; cis[7] = 0; es[7] = mk(32'h0F0F_00F0, 5'b00000, 1);
      cmds[8] = 4'h8; as[8] = 32'hA5A5_A5A5; bs[8] = 32'hA5A5_A5A5; cis[8] = 0; es[8] = mk(32'h0,         5'b00100, 1);
      cmds[9] = 4'h4; as[9] = 32'h8000_0000; bs[9] = 32'h1;         cis[9] = 0; es[9] = mk(32'h7FFF_FFFF, 5'b11000, 1);
      for (int i = 0; i < 10; i++) begin
         sb.push_back(es[i]);
         issue_and_collect(cmds[i], as[i], bs[i], cis[i], o);
         e = sb.pop_front();
         tests_run++;
         if (o !== e) begin
            fails++;
            $display("FAIL arith[%0d] cmd=%h: got %s, expected %s", i, cmds[i], fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_div();
      logic [3:0]  cmds[9];
      logic [31:0] as[9], bs[9];
      exp_t        es[9];
      exp_t        o, e;
      cmds[0] = 4'hC; as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;         es[0] = mk(32'hFFFF_FFFD, 5'b00010, ITER_LAT);
      cmds[1] = 4'hD; as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;         es[1] = mk(32'hFFFF_FFFF, 5'b00010, ITER_LAT);
      cmds[2] = 4'hC; as[2] = 32'd9;         bs[2] = 32'd0;         es[2] = mk(32'hFFFF_FFFF, 5'b00011, 1);
      cmds[3] = 4'hD; as[3] = 32'd9;         bs[3] = 32'd0;         es[3] = mk(32'h9,         5'b00001, 1);
      cmds[4] = 4'hC; as[4] = 32'd7;         bs[4] = 32'hFFFF_FFFE; es[4] = mk(32'hFFFF_FFFD, 5'b00010, ITER_LAT);
      cmds[5] = 4'hD; as[5] = 32'd7;         bs[5] = 32'hFFFF_FFFE; es[5] = mk(32'h1,         5'b00000, ITER_LAT);
      cmds[6] = 4'hC; as[6] = 32'd0;         bs[6] = 32'd5;         es[6] = mk(32'h0,         5'b00100, ITER_LAT);
      cmds[7] = 4'hD; as[7] = 32'h8000_0000; bs[7] = 32'hFFFF_FFFF; es[7] = mk(32'h0,         5'b00100, ITER_LAT);
      cmds[8] = 4'hC; as[8] = 32'd100;       bs[8] = 32'd7;         es[8] = mk(32'hE,         5'b00000, ITER_LAT);
      for (int i = 0; i < 9; i++) begin
         sb.push_back(es[i]);
         issue_and_collect(cmds[i], as[i], bs[i], 1'b0, o);
         e = sb.pop_front();
         tests_run++;
         if (o !== e) begin
            fails++;
            $display("FAIL div[%0d] cmd=%h: got %s, expected %s", i, cmds[i], fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_stall();
      exp_t        o, e;
      int          l;
      logic [31:0] snap_res;
      logic [4:0]  snap_f;
      logic        bad;
      sb.push_back(mk(32'h8000_0000, 5'b01010, ITER_LAT));
      @(negedge clk);
      out_ready = 1'b0;
      exe_cmd   = 4'hC;
      val1      = 32'h8000_0000;
      val2      = 32'hFFFF_FFFF;
      c_in      = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!out_valid && l < 200);
      o.res = alu_res;
      {o.c, o.v, o.z, o.n, o.dz} = {c, v, z, n, dz};
      o.lat = out_valid ? 8'(l) : 8'hFF;
      e = sb.pop_front();
      tests_run++;
      if (o !== e) begin
         fails++;
         $display("FAIL stall_result: got %s, expected %s", fmt(o), fmt(e));
      end
      snap_res = e.res;
      snap_f   = {e.c, e.v, e.z, e.n, e.dz};
      bad      = 1'b0;
      exe_cmd  = 4'h2;
      val1     = 32'd1;
      val2     = 32'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_res !== snap_res ||
             {c, v, z, n, dz} !== snap_f) begin
            bad = 1'b1;
         end
      end
      tests_run++;
      if (bad) begin
         fails++;
         $display("FAIL stall_hold: out_valid=%b in_ready=%b res=%h, expected 1 0 %h held",
                  out_valid, in_ready, alu_res, snap_res);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL stall_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_div();
      exp_t o, e;
      logic seen;
      @(negedge clk);
      exe_cmd  = 4'hC;
      val1     = 32'd100;
      val2     = 32'd7;
      c_in     = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_state: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      tests_run++;
      if (seen) begin
         fails++;
         $display("FAIL rst_mid_no_result: out_valid seen=%b, expected 0", seen);
      end
      sb.push_back(mk(32'd5, 5'b00000, 1));
      issue_and_collect(4'h2, 32'd2, 32'd3, 1'b0, o);
      e = sb.pop_front();
      tests_run++;
      if (o !== e) begin
         fails++;
         $display("FAIL rst_mid_add: got %s, expected %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_mul();
      logic [3:0]  cmds[4];
      logic [31:0] as[4], bs[4];
      exp_t        es[4];
      exp_t        o, e;
`ifdef SEQ_ALU_MUL_EN
      cmds[0] = 4'hB; as[0] = 32'hFFFF_FFFE; bs[0] = 32'd3;         es[0] = mk(32'hFFFF_FFFF, 5'b00010, ITER_LAT);
      cmds[1] = 4'hA; as[1] = 32'hFFFF_FFFE; bs[1] = 32'd3;         es[1] = mk(32'hFFFF_FFFA, 5'b00010, ITER_LAT);
      cmds[2] = 4'hA; as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF; es[2] = mk(32'h8000_0000, 5'b00010, ITER_LAT);
      cmds[3] = 4'hB; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; es[3] = mk(32'h0,         5'b00100, ITER_LAT);
`else
      cmds[0] = 4'hA; as[0] = 32'hFFFF_FFFE; bs[0] = 32'd3;         es[0] = mk(32'h0, 5'b00000, 1);
      cmds[1] = 4'hB; as[1] = 32'hFFFF_FFFE; bs[1] = 32'd3;         es[1] = mk(32'h0, 5'b00000, 1);
      cmds[2] = 4'h0; as[2] = 32'h1234_5678; bs[2] = 32'd9;         es[2] = mk(32'h0, 5'b00000, 1);
      cmds[3] = 4'hE; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; es[3] = mk(32'h0, 5'b00000, 1);
`endif
      for (int i = 0; i < 4; i++) begin
         sb.push_back(es[i]);
         issue_and_collect(cmds[i], as[i], bs[i], 1'b1, o);
         e = sb.pop_front();
         tests_run++;
         if (o !== e) begin
            fails++;
            $display("FAIL mul[%0d] cmd=%h: got %s, expected %s", i, cmds[i], fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_random();
      logic [3:0]  cmd;
      logic [31:0] a, b;
      logic        ci;
      exp_t        o, e;
      for (int i = 0; i < 24; i++) begin
         cmd = 4'($urandom_range(0, 15));
         a   = $urandom;
         b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if (i % 3 == 0) b = 32'($urandom_range(1, 20));
         ci  = 1'($urandom_range(0, 1));
         sb.push_back(model(cmd, a, b, ci));
         issue_and_collect(cmd, a, b, ci, o);
         e = sb.pop_front();
         tests_run++;
         if (o !== e) begin
            fails++;
            $display("FAIL random[%0d] cmd=%h a=%h b=%h ci=%b: got %s, expected %s",
                     i, cmd, a, b, ci, fmt(o), fmt(e));
         end
      end
   endtask

   // in_valid stays high throughout; commands presented while BUSY/DONE must be ignored.
   task automatic test_back_to_back();
      logic [3:0]  cmds[4];
      logic [31:0] as[4], bs[4];
      exp_t        o, e;
      int          got;
      int          guard;
      cmds[0] = 4'h2; as[0] = 32'd10;        bs[0] = 32'd20;
      cmds[1] = 4'hC; as[1] = 32'hFFFF_FF9C; bs[1] = 32'd9;
      cmds[2] = 4'h4; as[2] = 32'd3;         bs[2] = 32'd8;
      cmds[3] = 4'h8; as[3] = 32'hFFFF_0000; bs[3] = 32'h00FF_FF00;
      for (int i = 0; i < 4; i++) begin
         e     = model(cmds[i], as[i], bs[i], 1'b0);
         e.lat = 8'd0;
         sb.push_back(e);
      end
      @(negedge clk);
      exe_cmd  = cmds[0];
      val1     = as[0];
      val2     = bs[0];
      c_in     = 1'b0;
      in_valid = 1'b1;
      got      = 0;
      guard    = 0;
      while (got < 4 && guard < 400) begin
         @(negedge clk);
         guard++;
         if (out_valid) begin
            o.res = alu_res;
            {o.c, o.v, o.z, o.n, o.dz} = {c, v, z, n, dz};
            o.lat = 8'd0;
            e = sb.pop_front();
            tests_run++;
            if (o !== e) begin
               fails++;
               $display("FAIL b2b[%0d]: got %s, expected %s", got, fmt(o), fmt(e));
            end
            got++;
            if (got < 4) begin
               exe_cmd = cmds[got];
               val1    = as[got];
               val2    = bs[got];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      tests_run++;
      if (got != 4) begin
         fails++;
         $display("FAIL b2b_count: got %0d results, expected 4", got);
      end
      @(posedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      exe_cmd   = 4'h0;
      val1      = '0;
      val2      = '0;
      c_in      = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_arith();
      test_div();
      test_stall();
      test_reset_mid_div();
      test_mul();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (legal 8..64, even).
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: in_valid  in  1  command valid; in_ready  out  1  block can accept.
REQ-005 SHALL have ports: exe_cmd  in  4  operation code; val1, val2  in  WIDTH  signed operands; c_in  in  1  carry in.
REQ-006 SHALL have ports: out_valid  out  1  result valid; out_ready  in  1  consumer accepts.
REQ-007 SHALL have ports: alu_res  out  WIDTH  result; c, v, z, n  out  1  flags; dz  out  1  divide-by-zero.

Function
REQ-008 SHALL accept a command on the clk edge where in_valid & in_ready, registering exe_cmd, val1, val2, c_in.
REQ-009 SHALL implement FSM IDLE -> (single-cycle op) DONE; IDLE -> (iterative op) BUSY -> DONE; DONE -> IDLE on out_valid & out_ready.
REQ-010 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE; outputs held stable in DONE until accepted.
REQ-011 SHALL decode: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1100 DIV, 1101 REM, 1010 MULL, 1011 MULH; others yield res=0, flags 0, single-cycle.
REQ-012 SHALL compute ADD/ADC as val1+val2(+c_in) in WIDTH+1 unsigned bits, c = bit WIDTH.
REQ-013 SHALL compute SUB as val1+~val2+1 and SBC as val1+~val2+c_in, c = bit WIDTH (1 = no borrow).
REQ-014 SHALL set v for add/sub ops = signed overflow (operand signs equal (add) / differ (sub) and result sign differs from val1); v=0 for logic/MOV/MVN.
REQ-015 SHALL set c=0 for MOV, MVN and logic ops; z = (alu_res==0); n = alu_res[WIDTH-1] for every op.
REQ-016 SHALL complete single-cycle ops with out_valid asserted the cycle after acceptance (latency 1).
REQ-017 SHALL implement DIV/REM as signed radix-2 restoring division on magnitudes, one quotient bit per cycle, quotient truncated toward zero, remainder sign = sign of val1.
REQ-018 SHALL complete DIV/REM with out_valid asserted exactly WIDTH+1 cycles after acceptance.
REQ-019 SHALL on val2==0 skip BUSY: DIV res = all ones, REM res = val1, dz=1, out_valid latency 1.
REQ-020 SHALL on val1 = most-negative and val2 = -1: DIV res = val1, v=1; REM res = 0, v=0; full latency.
REQ-021 SHALL set dz=0, c=0, v=0 for DIV/REM except as REQ-019/REQ-020.
REQ-022 SHALL ignore in_valid while not in IDLE; a consumer stall (out_ready=0) SHALL hold DONE indefinitely with no data change.

Reset
REQ-023 SHALL on rst=1 at a clk edge enter IDLE, clear iteration counter and datapath registers; outputs: in_ready=1 on following cycle, out_valid=0, alu_res=0, c=v=z=n=dz=0 (z forced 0 while not DONE).
REQ-024 SHALL abandon any BUSY or DONE operation on rst, mid-iteration included, with no result ever presented.

Configuration
REQ-025 SHALL compile MULL/MULH in only when SEQ_ALU_MUL_EN is defined: signed shift-add multiply, one bit per cycle, MULL = low WIDTH bits, MULH = high WIDTH bits of 2*WIDTH product, latency WIDTH+1, c=v=0.
REQ-026 SHALL without SEQ_ALU_MUL_EN treat 1010/1011 as unknown commands (REQ-011) and contain no multiplier logic.

Structure
REQ-027 SHALL place opcode constants, FSM state encoding and latency constants in shared package seq_alu_pkg.
REQ-028 SHALL implement the iterative divider as sub-module seq_alu_div (start, done, WIDTH parameter); multiply iteration stays in seq_alu.

Verification
REQ-029 SHALL cover: WIDTH=32, ADD 0x7FFFFFFF+1 -> res 0x80000000, v=1, c=0, n=1, out_valid 1 cycle later.
REQ-030 SHALL cover: SUB 5-5 -> res 0, z=1, c=1, v=0; SBC 5-3 c_in=0 -> res 1, c=1.
REQ-031 SHALL cover: DIV -7/2 -> res -3 after 33 cycles; REM -7/2 -> res -1; DIV 9/0 -> res 0xFFFFFFFF, dz=1, latency 1.
REQ-032 SHALL cover: DIV 0x80000000/-1 -> res 0x80000000, v=1; out_ready held 0 for 10 cycles -> result stable, in_ready=0 throughout.
REQ-033 SHALL cover: rst asserted 10 cycles into DIV -> out_valid never asserts, in_ready=1 next cycle, new ADD 2+3 -> 5.
REQ-034 SHALL cover: with SEQ_ALU_MUL_EN, MULH -2*3 -> 0xFFFFFFFF, MULL -> 0xFFFFFFFA after 33 cycles; without it MULL -> res 0 latency 1.
